// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared helpers for the ARA invalidation path
// Purpose: holds the line-offset helper used to line-align invalidation
// addresses. No ports.
package ara_pkg;

  // Number of byte-offset bits inside one L1 D-cache line.
  function automatic int unsigned line_offset_bits(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - register-based FIFO with common_cells fifo_v3 interface
// Purpose: entry buffer with full/empty/usage status and registered storage.
// Ports: clk_i, rst_ni (async active-low), flush_i (clears contents),
//        testmode_i (unused), full_o, empty_o, usage_o (fill level mod DEPTH),
//        data_i/push_i (write side), data_o/pop_i (read side, head entry).
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  do_push, do_pop, bypass;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];

  // In fall-through mode an empty FIFO hands data_i straight to the reader.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && (cnt_q != '0);
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ara_inval_coalescer.sv
// rtl/ara_inval_coalescer.sv - merges repeated L1 line invalidations toward CVA6
// Purpose: buffers line-aligned invalidations, dropping a request whose line
// equals the most recently pushed line while that line is still queued.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   en_i                              coherence enable; low = accept and discard
//   inval_addr_i/valid_i/ready_o      upstream invalidations
//   inval_addr_o/valid_o/ready_i      downstream invalidations (line-aligned)
//   busy_o                            any entry buffered
//   merged_cnt_o, fwd_cnt_o           statistics (ARA_INVAL_STATS_EN), else 0
// Configuration macro: ARA_INVAL_STATS_EN enables the saturating counters.
module ara_inval_coalescer
  import ara_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineBytes = 16,
  parameter int unsigned Depth       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] inval_addr_i,
  input  logic                 inval_valid_i,
  output logic                 inval_ready_o,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 inval_valid_o,
  input  logic                 inval_ready_i,
  output logic                 busy_o,
  output logic [31:0]          merged_cnt_o,
  output logic [31:0]          fwd_cnt_o
);

  localparam int unsigned          OffBits  = line_offset_bits(L1LineBytes);
  localparam int unsigned          UsageW   = $clog2(Depth);
  localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << OffBits) - AddrWidth'(1));

  logic [AddrWidth-1:0] line, last_q;
  logic                 last_vld_q, init_q;
  logic                 full, empty, push, pop, accept;
  logic                 hit_raw, merge_hit, last_pop;
  logic [UsageW-1:0]    usage;

  assign line     = inval_addr_i & LineMask;
  assign pop      = !empty && inval_ready_i;
  // The only queued entry leaves this cycle: merging into it would lose the request.
  assign last_pop = (usage == UsageW'(1)) && !full && pop;
  assign hit_raw  = en_i && last_vld_q && (line == last_q);
  assign merge_hit = hit_raw && !last_pop;

  // Ready uses hit_raw so it never depends on inval_ready_i; when the
  // last_pop exception applies the FIFO holds one entry, so !full is true anyway.
  // init_q keeps ready low while in reset.
  assign inval_ready_o = init_q && (!en_i || hit_raw || !full);
  assign accept        = inval_valid_i && inval_ready_o;
  assign push          = accept && en_i && !merge_hit;

  assign inval_valid_o = !empty;
  assign busy_o        = !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q     <= 1'b0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (push) begin
        last_q     <= line;
        last_vld_q <= 1'b1;
      end else if (empty || last_pop) begin
        last_vld_q <= 1'b0;
      end
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (AddrWidth),
    .DEPTH        (Depth),
    .dtype        (logic [AddrWidth-1:0])
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (full),
    .empty_o    (empty),
    .usage_o    (usage),
    .data_i     (line),
    .push_i     (push),
    .data_o     (inval_addr_o),
    .pop_i      (pop)
  );

`ifdef ARA_INVAL_STATS_EN
  logic [31:0] merged_q, fwd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      merged_q <= '0;
      fwd_q    <= '0;
    end else begin
      if (accept && merge_hit && (merged_q != '1)) merged_q <= merged_q + 1'b1;
      if (pop && (fwd_q != '1))                    fwd_q    <= fwd_q + 1'b1;
    end
  end

  assign merged_cnt_o = merged_q;
  assign fwd_cnt_o    = fwd_q;
`else
  assign merged_cnt_o = '0;
  assign fwd_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_ara_inval_coalescer.sv
// tb/tb_ara_inval_coalescer.sv - self-checking bench for ara_inval_coalescer
module tb_ara_inval_coalescer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, v, r;
  logic [63:0] a;
  logic        ready_o, valid_o, busy;
  logic [63:0] addr_o;
  logic [31:0] merged_cnt, fwd_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];
  logic [63:0] m_last;
  bit          m_lv, m_live;
  longint      m_merged, m_fwd;
  bit          seen_rdy;

  always #5 clk = ~clk;

  ara_inval_coalescer #(.AddrWidth(64), .L1LineBytes(16), .Depth(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .inval_addr_i  (a),
    .inval_valid_i (v),
    .inval_ready_o (ready_o),
    .inval_addr_o  (addr_o),
    .inval_valid_o (valid_o),
    .inval_ready_i (r),
    .busy_o        (busy),
    .merged_cnt_o  (merged_cnt),
    .fwd_cnt_o     (fwd_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input longint c);
`ifdef ARA_INVAL_STATS_EN
    return (c > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : c;
`else
    return (c < 0) ? 64'h1 : 64'h0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_lv = 0; m_live = 0;
    m_merged = 0; m_fwd = 0;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic cycle(input bit vi, input logic [63:0] ai, input bit ri, input bit eni);
    logic [63:0] line;
    bit pop, hit, rdy, acc, push;
    v = vi; a = ai; r = ri; en = eni;
    #1;
    line = ai & ~64'hF;
    pop  = (mq.size() != 0) && ri;
    hit  = eni && m_lv && (line == m_last) && !((mq.size() == 1) && pop);
    if (!m_live)   rdy = 0;
    else if (!eni) rdy = 1;
    else if (hit)  rdy = 1;
    else           rdy = (mq.size() < DEPTH);
    chk("valid", valid_o, mq.size() != 0);
    chk("busy", busy, mq.size() != 0);
    if (mq.size() != 0) chk("addr", addr_o, mq[0]);
    chk("ready", ready_o, rdy);
    chk("merged_cnt", merged_cnt, exp_cnt(m_merged));
    chk("fwd_cnt", fwd_cnt, exp_cnt(m_fwd));
    seen_rdy = ready_o;
    acc  = vi && rdy;
    push = acc && eni && !hit;
    @(posedge clk);
    if (acc && hit) m_merged++;
    if (pop) begin
      m_fwd++;
      void'(mq.pop_front());
    end
    if (push) begin
      mq.push_back(line);
      m_last = line;
      m_lv = 1;
    end else if (mq.size() == 0) begin
      m_lv = 0;
    end
    m_live = 1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() != 0; i++) cycle(0, 64'h0, 1, 1);
    chk("drain_done", mq.size() == 0, 1);
    chk("drain_valid", valid_o, 0);
  endtask

  initial begin
    rst_n = 0; en = 0; v = 0; r = 0; a = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_merged", merged_cnt, 0);
    chk("rst_fwd", fwd_cnt, 0);
    rst_n = 1;
    cycle(0, 64'h0, 0, 1);

    // Back-to-back hits on the same line collapse into one entry.
    cycle(1, 64'h1004, 0, 1);
    cycle(1, 64'h1008, 0, 1);
    cycle(0, 64'h0, 0, 1);
    chk("merge_size", mq.size(), 1);
    chk("merge_addr", addr_o, 64'h1000);
`ifdef ARA_INVAL_STATS_EN
    chk("merge_cnt", merged_cnt, 1);
`else
    chk("merge_cnt", merged_cnt, 0);
`endif
    drain();

    // Only the most recent line merges.
    cycle(1, 64'h2000, 0, 1);
    cycle(1, 64'h3000, 0, 1);
    cycle(1, 64'h2000, 0, 1);
    chk("order_size", mq.size(), 3);
    chk("order_head0", addr_o, 64'h2000);
    cycle(0, 64'h0, 1, 1);
    chk("order_head1", addr_o, 64'h3000);
    cycle(0, 64'h0, 1, 1);
    chk("order_head2", addr_o, 64'h2000);
    drain();

    // Full FIFO: a same-cycle pop does not open ready.
    for (int i = 1; i <= 4; i++) cycle(1, 64'(i) << 8, 0, 1);
    cycle(1, 64'h500, 1, 1);
    chk("full_ready_low", seen_rdy, 0);
    cycle(1, 64'h500, 0, 1);
    chk("full_ready_rise", seen_rdy, 1);
    chk("full_size", mq.size(), 4);
    drain();

    // Single entry popping while a new request arrives.
    cycle(1, 64'h4000, 0, 1);
    cycle(1, 64'h4010, 1, 1);
    chk("pop_push_addr", addr_o, 64'h4010);
    drain();
    cycle(1, 64'h4000, 0, 1);
    cycle(1, 64'h4008, 1, 1);
    chk("pop_same_valid", valid_o, 1);
    chk("pop_same_addr", addr_o, 64'h4000);
    drain();

    // Coherence disabled: every request accepted and discarded.
    for (int i = 0; i < 10; i++) cycle(1, 64'(i) * 64'h40 + 64'h4, 0, 0);
    chk("dis_valid", valid_o, 0);
    chk("dis_ready", seen_rdy, 1);

    // Reset mid-operation drops buffered entries.
    cycle(1, 64'h7000, 0, 1);
    cycle(1, 64'h7100, 0, 1);
    cycle(1, 64'h7200, 0, 1);
    chk("prerst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) cycle(0, 64'h0, 1, 1);
    chk("postrst_fwd", fwd_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ara_inval_coalescer.md
ARA_INVAL_COALESCER -- requirements
Module: ara_inval_coalescer

Interface
REQ-001 SHALL have parameter AddrWidth, default 64: invalidation address width.
REQ-002 SHALL have parameter L1LineBytes, default 16: L1 D-cache line size in bytes; power of two, at least 4.
REQ-003 SHALL have parameter Depth, default 4: buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_ni, input, 1: reset; asynchronous and active-low.
REQ-006 SHALL have port en_i, input, 1: coherence enable from the accelerator request.
REQ-007 SHALL have ports inval_addr_i (input, AddrWidth), inval_valid_i (input, 1) and inval_ready_o (output, 1): upstream invalidations from the AXI invalidation filter.
REQ-008 SHALL have ports inval_addr_o (output, AddrWidth), inval_valid_o (output, 1) and inval_ready_i (input, 1): downstream invalidations to CVA6.
REQ-009 SHALL have port busy_o, output, 1: high while any entry is buffered.
REQ-010 SHALL have ports merged_cnt_o and fwd_cnt_o, output, 32 bits each: statistics counters.

Function
REQ-011 SHALL compute line = inval_addr_i with its low log2(L1LineBytes) bits cleared; all stored and output addresses are line-aligned.
REQ-012 SHALL count a handshake on either side only on a cycle where valid and ready are both high; valid SHALL NOT depend combinationally on ready.
REQ-013 SHALL hold entries in a FIFO; inval_valid_o = FIFO not empty; inval_addr_o = head entry, driven from a register.
REQ-014 SHALL keep last_q and last_vld_q for the most recently pushed line.
REQ-015 SHALL raise merge hit when en_i, last_vld_q and line == last_q are all true, except when the FIFO holds exactly one entry and it pops in the same cycle.
REQ-016 SHALL, on merge hit, assert inval_ready_o, accept the request and push nothing.
REQ-017 SHALL, when en_i is high and there is no merge hit, set inval_ready_o = !full; an accepted request pushes the line and loads last_q.
REQ-018 SHALL NOT let a same-cycle pop free a full FIFO for a push; there is no ready path from inval_ready_i to inval_ready_o.
REQ-019 SHALL, when en_i is low, hold inval_ready_o = 1 and accept and discard every request; buffered entries keep draining.
REQ-020 SHALL give a minimum latency of 1 cycle from acceptance to the matching inval_valid_o.
REQ-021 SHALL clear last_vld_q when the FIFO becomes empty with no push in the same cycle.
REQ-022 SHALL deassert busy_o exactly when the FIFO is empty.
REQ-023 SHALL forward entries strictly in arrival order with no reordering.

Reset
REQ-024 SHALL, on reset, empty the FIFO and clear last_vld_q, last_q and both counters.
REQ-025 SHALL, on reset, drive inval_valid_o=0, inval_addr_o=0, busy_o=0 and inval_ready_o=0.
REQ-026 SHALL, on a reset asserted mid-operation, drop buffered entries without forwarding them.

Configuration
REQ-027 SHALL, with ARA_INVAL_STATS_EN defined, count merge hits in merged_cnt_o and downstream handshakes in fwd_cnt_o, each saturating at 0xFFFFFFFF.
REQ-028 SHALL, without ARA_INVAL_STATS_EN, tie both counter outputs to 0 and instantiate no counter flops.

Structure
REQ-029 SHALL place the line-offset constant helper (log2 of L1LineBytes) in ara_pkg.
REQ-030 SHALL use fifo_v3 from common_cells as the only sub-module, as the entry buffer.

Verification
REQ-031 SHALL cover: en_i=1, push 0x1004 then 0x1008 back-to-back with inval_ready_i=0 -> one entry 0x1000, merged_cnt_o=1.
REQ-032 SHALL cover: push 0x2000, 0x3000, 0x2000 -> three entries in that order, since only the last line merges.
REQ-033 SHALL cover: Depth=4, inval_ready_i=0, push 5 distinct lines -> inval_ready_o=0 after the fourth; with a pop on that cycle, ready stays 0, then rises the next cycle.
REQ-034 SHALL cover: one entry 0x4000 popping while 0x4010 arrives (L1LineBytes=16, distinct line) -> pushed; with 0x4008 instead -> pushed, not merged (REQ-015 exception).
REQ-035 SHALL cover: en_i=0, 10 requests -> all accepted, inval_valid_o stays 0, counters unchanged.
REQ-036 SHALL cover: rst_ni pulsed low with 3 entries buffered -> inval_valid_o=0 and busy_o=0 at once; nothing forwarded after release.
